// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel microsecond timer: channel mode
// and channel state.
package timer_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counts shared 1 us ticks down from a latched period and
// raises a single-cycle expiry pulse, in one-shot or periodic mode.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load,
    output logic             q,
    output logic             busy
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] r_q, r_d;
    logic [CNT_W-1:0] l_q, l_d;
    logic             m_q, m_d;
    logic             q_q, q_d;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        l_d     = l_q;
        m_d     = m_q;
        q_d     = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            // A zero period is treated as a stop request.
            if (load == '0) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_RUN;
                r_d     = load;
                l_d     = load;
                m_d     = periodic;
            end
        end else if (state_q == ST_RUN && tick) begin
            if (r_q == CNT_W'(1)) begin
                q_d = 1'b1;
                if (m_q == MODE_PERIODIC) r_d = l_q;
                else                      state_d = ST_IDLE;
            end else begin
                r_d = r_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            l_q     <= '0;
            m_q     <= MODE_ONESHOT;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            l_q     <= l_d;
            m_q     <= m_d;
            q_q     <= q_d;
        end
    end

    assign q    = q_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: rtl/timer_multi_us.sv
// Multi-channel microsecond timer: a shared prescaler produces a 1 us tick
// that drives N_CH independent countdown channels.
module timer_multi_us
    import timer_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 36,
    parameter int N_CH         = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  i_clk_36MHz,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic [N_CH-1:0]       i_start,
    input  logic [N_CH-1:0]       i_stop,
    input  logic [N_CH-1:0]       i_periodic,
    input  logic [N_CH*CNT_W-1:0] i_load,
    output logic [N_CH-1:0]       o_q,
    output logic [N_CH-1:0]       o_busy
);

    localparam int P_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [P_W-1:0] P_MAX = P_W'(CLK_FREQ_MHZ - 1);

    logic [P_W-1:0] p_q, p_d;
    logic           tick;

    // Prescaler restarts from 0 whenever the global enable is dropped.
    always_comb begin
        p_d = '0;
        if (i_en && p_q != P_MAX) p_d = p_q + P_W'(1);
    end

    always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
        if (!i_reset) p_q <= '0;
        else          p_q <= p_d;
    end

    assign tick = i_en && (p_q == P_MAX);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (i_clk_36MHz),
            .rst_n    (i_reset),
            .tick     (tick),
            .start    (i_start[g]),
            .stop     (i_stop[g]),
            .periodic (i_periodic[g]),
            .load     (i_load[g*CNT_W +: CNT_W]),
            .q        (o_q[g]),
            .busy     (o_busy[g])
        );
    end

endmodule

// File: tb/tb_timer_multi_us.sv
// Directed self-checking bench for timer_multi_us with default parameters.
module tb_timer_multi_us;

    localparam int F     = 36;
    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic [N_CH-1:0]       start, stop, periodic;
    logic [N_CH*CNT_W-1:0] load;
    logic [N_CH-1:0]       q, busy;

    int n_assert = 0;
    int n_fail   = 0;

    timer_multi_us #(.CLK_FREQ_MHZ(F), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .i_clk_36MHz (clk),
        .i_reset     (rst_n),
        .i_en        (en),
        .i_start     (start),
        .i_stop      (stop),
        .i_periodic  (periodic),
        .i_load      (load),
        .o_q         (q),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles until o_q[ch] is seen high, or -1 if it never is within limit.
    task automatic wait_q(input int ch, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (q[ch]) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic start_ch(input int ch, input int ld, input logic per, input logic also_stop);
        load[ch*CNT_W +: CNT_W] = CNT_W'(ld);
        periodic[ch] = per;
        start[ch]    = 1'b1;
        stop[ch]     = also_stop;
        @(negedge clk);
        start[ch] = 1'b0;
        stop[ch]  = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0; en = 1'b1;
        start = '0; stop = '0; periodic = '0; load = '0;
        cyc(3);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc(5);

        // ch0 periodic L=3
        start_ch(0, 3, 1'b1, 1'b0);
        chk("ch0_busy_rise", int'(busy[0]), 1);
        wait_q(0, 120, n);
        chk_rng("ch0_first_lat", n, 2*F+1, 3*F);
        wait_q(0, 120, n);
        chk("ch0_period1", n, 3*F);
        chk("ch0_others_idle", int'({q[3:1], busy[3:1]}), 0);
        wait_q(0, 120, n);
        chk("ch0_period2", n, 3*F);
        chk("ch0_busy_held", int'(busy[0]), 1);

        // ch1 one-shot L=1
        start_ch(1, 1, 1'b0, 1'b0);
        wait_q(1, 40, n);
        chk_rng("ch1_lat", n, 1, F);
        chk("ch1_busy_fall", int'(busy[1]), 0);
        wait_q(1, 500, n);
        chk("ch1_no_repeat", n, -1);

        // ch2 periodic L=5, stop after two pulses, restart L=2
        start_ch(2, 5, 1'b1, 1'b0);
        wait_q(2, 200, n);
        chk_rng("ch2_first_lat", n, 4*F+1, 5*F);
        wait_q(2, 200, n);
        chk("ch2_period5", n, 5*F);
        stop[2] = 1'b1;
        cyc(1);
        stop[2] = 1'b0;
        chk("ch2_stop_busy", int'(busy[2]), 0);
        wait_q(2, 400, n);
        chk("ch2_stop_quiet", n, -1);
        start_ch(2, 2, 1'b1, 1'b0);
        wait_q(2, 80, n);
        chk_rng("ch2_restart_lat", n, F+1, 2*F);
        wait_q(2, 80, n);
        chk("ch2_period2", n, 2*F);

        // ch3 start+stop together, then zero-load start
        start_ch(3, 7, 1'b0, 1'b1);
        chk("ch3_startstop_busy", int'(busy[3]), 0);
        wait_q(3, 300, n);
        chk("ch3_startstop_quiet", n, -1);
        start_ch(3, 0, 1'b0, 1'b0);
        chk("ch3_zero_busy", int'(busy[3]), 0);
        wait_q(3, 100, n);
        chk("ch3_zero_quiet", n, -1);

        // zero-load start on a running channel stops it
        start_ch(0, 0, 1'b1, 1'b0);
        chk("ch0_zero_stop_busy", int'(busy[0]), 0);
        wait_q(0, 150, n);
        chk("ch0_zero_stop_quiet", n, -1);

        // enable gap mid-count: prescaler progress is discarded
        start_ch(0, 2, 1'b1, 1'b0);
        wait_q(0, 80, n);
        chk_rng("ch0_l2_lat", n, F+1, 2*F);
        cyc(30);
        en = 1'b0;
        wait_q(0, 200, n);
        chk("gap_quiet", n, -1);
        chk("gap_busy", int'(busy[0]), 1);
        en = 1'b1;
        wait_q(0, 200, n);
        chk("gap_resume", n, 2*F);

        // asynchronous reset while ch0 and ch1 run
        start_ch(1, 10, 1'b0, 1'b0);
        cyc(5);
        chk("pre_rst_busy", int'(busy[1:0]), 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (500) begin
            @(negedge clk);
            if (q != '0 || busy != '0) seen++;
        end
        chk("post_rst_quiet", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_multi_us.md
# timer_multi_us

Multi-channel microsecond timer for the 36 MHz clock domain. A shared prescaler derives a 1 µs tick from the system clock. N independent channels count down a programmable number of ticks and emit a single-cycle expiry pulse in one-shot or periodic mode. It replaces single-purpose fixed-period timers for game-logic timing: sprite step rates, shot cooldowns, sound note lengths.

## Interface
- CLK_FREQ_MHZ, 36: clock cycles per microsecond; prescaler modulus.
- N_CH, 4: number of timer channels (1..16).
- CNT_W, 16: width of per-channel period value, in µs.
- i_clk_36MHz  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_en  in  1  global enable; 0 holds prescaler at 0 and freezes all channels.
- i_start  in  N_CH  per-channel start/restart strobe (1 cycle).
- i_stop  in  N_CH  per-channel stop strobe (1 cycle).
- i_periodic  in  N_CH  mode sampled at start: 1 = periodic, 0 = one-shot.
- i_load  in  N_CH*CNT_W  period per channel in µs; channel c at bits [c*CNT_W +: CNT_W]; sampled at start.
- o_q  out  N_CH  registered expiry pulse, 1 cycle wide per expiry.
- o_busy  out  N_CH  registered; 1 while channel is in RUN.

## Operation
- Prescaler p: 0..CLK_FREQ_MHZ-1. Increments when i_en=1 and wraps to 0 after MAX = CLK_FREQ_MHZ-1. Forced to 0 when i_en=0.
- tick = i_en && (p == MAX), combinational. It is shared by all channels. Start does not resynchronise the prescaler.
- Per-channel state: IDLE, RUN. Per-channel registers: remaining count r, latched period L, latched mode M.
- IDLE + i_start with load != 0: latch L = load and M = i_periodic, set r = load, go to RUN.
- Any state + i_start with load == 0: go to IDLE (this is a stop). No pulse.
- RUN + i_start with load != 0: restart. Relatch L and M, set r = load, stay in RUN. No pulse that cycle, even if a tick coincides.
- RUN + tick, r > 1: r decrements by 1.
- RUN + tick, r == 1: o_q pulses on the next cycle. If M = 1, r reloads to L and the channel stays in RUN. If M = 0, the channel goes to IDLE and o_busy falls on the same edge that raises o_q.
- Priority per channel, in one cycle: i_stop > i_start > tick.
- i_stop in RUN: go to IDLE. No pulse. r holds (don't-care).
- i_en = 0: channels keep state and r. No ticks occur and no o_q pulses.
- Channels are fully independent. Simultaneous expiries on several channels give simultaneous o_q bits.
- No arithmetic overflow is possible: r only decrements from ≤ 2^CNT_W-1 down to 1.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream): p=0, every channel IDLE, r=0, L=0, M=0, o_q=0, o_busy=0.
- Reset asserted mid-run: outputs clear immediately. No pulse is generated after release.
- o_busy rises on the clock edge that samples i_start.
- Latency from start to first o_q, with i_en held at 1: between (L-1)*CLK_FREQ_MHZ+1 and L*CLK_FREQ_MHZ cycles. The spread comes from prescaler phase.
- Periodic spacing between o_q pulses: exactly L*CLK_FREQ_MHZ cycles while i_en stays at 1.
- o_q is high the cycle after the edge where p == MAX.

## Structure
- Shared package timer_pkg holds localparams MODE_ONESHOT=0 and MODE_PERIODIC=1, and the channel state encoding ST_IDLE and ST_RUN.
- Sub-module timer_channel (params CNT_W) contains one channel's FSM and counter. Its inputs are tick, start, stop, periodic and load; its outputs are q and busy.
- The top module holds the prescaler and a generate loop of N_CH timer_channel instances.

## Test plan
- Default params, i_en=1 from reset, ch0 periodic with L=3: o_q[0] pulses every 108 cycles. o_busy[0] stays 1. Other channels stay 0.
- ch1 one-shot with L=1: exactly one o_q[1] pulse within 36 cycles of start. o_busy[1] falls on the same edge. No further pulses in 500 cycles.
- ch2 periodic with L=5, i_stop after 2 pulses: no further pulses, o_busy[2]=0. A restart with L=2 gives pulses 72 cycles apart.
- i_start and i_stop in the same cycle on ch3: channel ends IDLE. Start with load=0: o_busy stays 0 and no pulse.
- Drop i_en for 200 cycles mid-count on ch0 (L=2): no pulse during the gap, and the expiry is delayed by the gap. Re-enable: resumes with p from 0.
- Assert i_reset asynchronously between edges while ch0 and ch1 run: o_q and o_busy go 0 immediately. After release, no pulses until a new start.
